instr_fetch_unit: RTL

//  Instruction fetch stage directly upstream of the instruction decoder.

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack memory port and
// hands {instruction, pc} to the decoder over valid/ready, with redirect-driven flushing.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  input  logic              dec_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              imem_req_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       instruction_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic              inst_valid_q;

  logic [ADDR_W-1:0] npc_d;
  logic [ADDR_W-1:0] pc_inc_d;

  // Redirect targets are word-aligned; the low two bits are simply masked off.
  assign npc_d    = redirect_pc & ~ADDR_W'(3);
  assign pc_inc_d = pc_q + ADDR_W'(4);

  // NOTE: every register, including the held instruction word, sits on the async reset and
  // is written with non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instruction_q <= '0;
      pc_out_q      <= '0;
      inst_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (redirect) begin
            pc_q <= npc_d;
          end else begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
            state_q     <= FETCH;
          end
        end

        FETCH: begin
          if (redirect) begin
            pc_q <= npc_d;
            if (imem_ack) begin
              // Wrong-path word arrives with the redirect: drop it and refetch at once.
              imem_addr_q <= npc_d;
            end else begin
              state_q <= DRAIN;
            end
          end else if (imem_ack) begin
            instruction_q <= imem_rdata;
            pc_out_q      <= pc_q;
            inst_valid_q  <= 1'b1;
            pc_q          <= pc_inc_d;
            imem_req_q    <= 1'b0;
            state_q       <= ISSUE;
          end
        end

        ISSUE: begin
          if (redirect) begin
            inst_valid_q <= 1'b0;
            pc_q         <= npc_d;
            imem_addr_q  <= npc_d;
            imem_req_q   <= 1'b1;
            state_q      <= FETCH;
          end else if (dec_ready) begin
            inst_valid_q <= 1'b0;
            imem_addr_q  <= pc_q;
            imem_req_q   <= 1'b1;
            state_q      <= FETCH;
          end
        end

        DRAIN: begin
          // The outstanding request must complete before a new address can be issued.
          if (redirect) begin
            pc_q <= npc_d;
          end
          if (imem_ack) begin
            imem_addr_q <= redirect ? npc_d : pc_q;
            state_q     <= FETCH;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instruction_q;
  assign pc          = pc_out_q;
  assign inst_valid  = inst_valid_q;

endmodule
